config_frame_writer: RTL

//   Write side of the tile configuration-frame interface. Accepts a 32-bit configuration word stream
//   (valid/ready) and decodes sync/header/data words. Drives a stable FrameData word, then a one-hot

---
 rtl/config_frame_writer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/config_frame_writer.sv
// Configuration-frame write engine: decodes a sync/header/data word stream
// and fires one-hot frame/column strobes with a full setup cycle on FrameData.
module config_frame_writer #(
  parameter int          FrameBitsPerRow = 32,
  parameter int          MaxFramesPerCol = 20,
  parameter int          NumberOfCols    = 16,
  parameter int          StrobeCycles    = 1,
  parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [31:0]                WordData,
  input  logic                       WordValid,
  output logic                       WordReady,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [NumberOfCols-1:0]    ColStrobe,
  output logic                       Synced,
  output logic                       Error,
  output logic [15:0]                FrameCount
);

  typedef enum logic [2:0] {
    DESYNC,
    HDR,
    DATA,
    SETUP,
    STROBE
  } state_t;

  state_t state;
  state_t stateNext;

  logic [7:0] colQ;
  logic [7:0] frameQ;
  logic [3:0] cntQ;

  logic       accept;
  logic       isSync;
  logic [7:0] hdrCol;
  logic [7:0] hdrFrame;
  logic       hdrBad;

  logic [MaxFramesPerCol-1:0] frameHot;
  logic [NumberOfCols-1:0]    colHot;

  assign accept   = WordValid && WordReady;
  assign isSync   = (WordData == SyncWord);
  assign hdrCol   = WordData[15:8];
  assign hdrFrame = WordData[7:0];
  assign hdrBad   = (int'(hdrCol) >= NumberOfCols) ||
                    (int'(hdrFrame) >= MaxFramesPerCol);

  assign frameHot = MaxFramesPerCol'(1) << frameQ;
  assign colHot   = NumberOfCols'(1) << colQ;

  always_comb begin
    stateNext = state;
    unique case (state)
      DESYNC: if (accept && isSync) stateNext = HDR;
      HDR: begin
        if (accept) begin
          if (WordData[31])  stateNext = DESYNC;
          else if (!hdrBad)  stateNext = DATA;
        end
      end
      DATA:   if (accept) stateNext = SETUP;
      SETUP:  stateNext = STROBE;
      STROBE: if (cntQ == 4'd1) stateNext = HDR;
      default: stateNext = DESYNC;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= DESYNC;
      WordReady   <= 1'b1;
      Synced      <= 1'b0;
      colQ        <= '0;
      frameQ      <= '0;
      cntQ        <= '0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      ColStrobe   <= '0;
      Error       <= 1'b0;
      FrameCount  <= '0;
    end else begin
      state     <= stateNext;
      WordReady <= (stateNext == DESYNC) ||
                   (stateNext == HDR) ||
                   (stateNext == DATA);
      Synced    <= (stateNext != DESYNC);

      // strobes are registered from the next state so they are glitch-free
      FrameStrobe <= (stateNext == STROBE) ? frameHot : '0;
      ColStrobe   <= (stateNext == STROBE) ? colHot : '0;

      unique case (state)
        DESYNC: begin
          if (accept && isSync) begin
            Error      <= 1'b0;
            FrameCount <= '0;
          end
        end
        HDR: begin
          if (accept && !WordData[31]) begin
            if (hdrBad) begin
              Error <= 1'b1;
            end else begin
              colQ   <= hdrCol;
              frameQ <= hdrFrame;
            end
          end
        end
        DATA: begin
          if (accept) FrameData <= WordData[FrameBitsPerRow-1:0];
        end
        SETUP: cntQ <= 4'(StrobeCycles);
        STROBE: begin
          cntQ <= cntQ - 4'd1;
          if (cntQ == 4'd1 && FrameCount != 16'hFFFF)
            FrameCount <= FrameCount + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
